// File: rtl/afe_calib_sequencer.sv
// Multi-channel LED/AFE calibration: per-channel SAR DC-comp search, monotonic PGA gain search,
// then slot-multiplexed run mode. Optional CAL_AVG4_EN averages 4 samples per calibration step.
module afe_calib_sequencer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADC_W      = 8,
  parameter int unsigned DAC_W      = 7,
  parameter int unsigned GAIN_W     = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SLOT_CYC   = 64,
  parameter int unsigned TARGET_MID = 127,
  parameter int unsigned CLIP_HI    = 250,
  parameter int unsigned CLIP_LO    = 5
) (
  input  logic                                         CLK,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [ADC_W-1:0]                             adc_data,
  input  logic                                         adc_valid,
  output logic [NUM_CH-1:0]                            led_en,
  output logic [DAC_W-1:0]                             dc_comp,
  output logic [GAIN_W-1:0]                            pga_gain,
  output logic                                         busy,
  output logic                                         cal_done,
  output logic [NUM_CH-1:0]                            cal_err,
  output logic [ADC_W-1:0]                             sample_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch,
  output logic                                         sample_valid
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(SLOT_CYC + 1);
  localparam int unsigned BIT_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;

  localparam logic [CNT_W-1:0]  SETTLE    = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [ADC_W-1:0]  TARGET    = ADC_W'(TARGET_MID);
  localparam logic [ADC_W-1:0]  CLIP_H    = ADC_W'(CLIP_HI);
  localparam logic [ADC_W-1:0]  CLIP_L    = ADC_W'(CLIP_LO);
  localparam logic [DAC_W-1:0]  DAC_MSB   = DAC_W'(1 << (DAC_W - 1));
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StDcSearch, StGainSearch, StNextCh, StRun} state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]   ch_q;
  logic [NUM_CH-1:0] led_q;
  logic [DAC_W-1:0]  dc_q;
  logic [GAIN_W-1:0] gain_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] err_q;
  logic [DAC_W-1:0]  dc_tab_q   [NUM_CH];
  logic [GAIN_W-1:0] gain_tab_q [NUM_CH];
  logic [ADC_W-1:0]  sdata_q;
  logic [CH_W-1:0]   sch_q;
  logic              svalid_q;
  logic              captured_q;

  logic              settled, step_fire, clip, gain_max, last_ch, ld_cal;
  logic [ADC_W-1:0]  step_sample;
  logic [DAC_W-1:0]  dc_kept;
  logic [CH_W-1:0]   nxt_ch, ld_ch;

`ifdef CAL_AVG4_EN
  logic [1:0]        avg_q;
  logic [ADC_W+1:0]  sum_q, sum_next;
`endif

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) oh[i] = (idx == CH_W'(i));
    return oh;
  endfunction

  always_comb begin
    settled = (cnt_q == '0);
`ifdef CAL_AVG4_EN
    sum_next    = sum_q + {2'b00, adc_data};
    step_fire   = settled && adc_valid && (avg_q == 2'd3);
    step_sample = sum_next[ADC_W+1:2];
`else
    step_fire   = settled && adc_valid;
    step_sample = adc_data;
`endif
    clip     = (step_sample > CLIP_H) || (step_sample < CLIP_L);
    gain_max = (gain_q == '1);
    dc_kept  = (step_sample < TARGET) ? (dc_q & ~(DAC_W'(1) << bit_q)) : dc_q;
    last_ch  = (ch_q == LAST_CH);
    nxt_ch   = last_ch ? '0 : ch_q + 1'b1;
    ld_ch    = (state_q == StNextCh) ? nxt_ch : '0;
    // Entry into a channel's DC search: fresh start, restart from RUN, or advancing channels.
    ld_cal   = ((state_q == StIdle || state_q == StRun) && start) ||
               ((state_q == StNextCh) && !last_ch);
  end

  always_ff @(posedge CLK) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (start) state_d = StDcSearch;
      StDcSearch:   if (step_fire && bit_q == '0) state_d = StGainSearch;
      StGainSearch: if (step_fire && (clip || gain_max)) state_d = StNextCh;
      StNextCh:     state_d = last_ch ? StRun : StDcSearch;
      StRun:        if (start) state_d = StDcSearch;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StDcSearch) || (state_q == StGainSearch);
    cal_done     = (state_q == StRun);
    led_en       = led_q;
    dc_comp      = dc_q;
    pga_gain     = gain_q;
    cal_err      = err_q;
    sample_data  = sdata_q;
    sample_ch    = sch_q;
    sample_valid = svalid_q;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      ch_q       <= '0;
      led_q      <= '0;
      dc_q       <= '0;
      gain_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      sdata_q    <= '0;
      sch_q      <= '0;
      svalid_q   <= 1'b0;
      captured_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        dc_tab_q[i]   <= '0;
        gain_tab_q[i] <= '0;
      end
`ifdef CAL_AVG4_EN
      avg_q <= '0;
      sum_q <= '0;
`endif
    end else begin
      svalid_q <= 1'b0;
      if (ld_cal) begin
        ch_q   <= ld_ch;
        led_q  <= onehot(ld_ch);
        dc_q   <= DAC_MSB;
        gain_q <= '0;
        bit_q  <= BIT_W'(DAC_W - 1);
        cnt_q  <= SETTLE;
        if (state_q == StRun) err_q <= '0;
`ifdef CAL_AVG4_EN
        avg_q <= '0;
        sum_q <= '0;
`endif
      end else begin
        case (state_q)
          StDcSearch, StGainSearch: begin
            if (!settled) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (step_fire) begin
              cnt_q <= SETTLE;
`ifdef CAL_AVG4_EN
              avg_q <= '0;
              sum_q <= '0;
`endif
              if (state_q == StDcSearch) begin
                if (bit_q == '0) begin
                  dc_q          <= dc_kept;
                  dc_tab_q[ch_q] <= dc_kept;
                end else begin
                  dc_q  <= dc_kept | (DAC_W'(1) << (bit_q - 1'b1));
                  bit_q <= bit_q - 1'b1;
                end
              end else if (clip) begin
                gain_tab_q[ch_q] <= (gain_q == '0) ? '0 : gain_q - 1'b1;
                if (gain_q == '0) err_q[ch_q] <= 1'b1;
              end else if (gain_max) begin
                gain_tab_q[ch_q] <= gain_q;
              end else begin
                gain_q <= gain_q + 1'b1;
              end
            end
`ifdef CAL_AVG4_EN
            else if (adc_valid) begin
              avg_q <= avg_q + 1'b1;
              sum_q <= sum_next;
            end
`endif
          end
          StNextCh: begin
            // Only reached on the last channel; enter RUN at slot 0 of channel 0.
            cnt_q      <= '0;
            ch_q       <= nxt_ch;
            led_q      <= onehot(nxt_ch);
            dc_q       <= dc_tab_q[nxt_ch];
            gain_q     <= gain_tab_q[nxt_ch];
            captured_q <= 1'b0;
          end
          StRun: begin
            if (cnt_q >= SETTLE && !captured_q && adc_valid) begin
              sdata_q    <= adc_data;
              sch_q      <= ch_q;
              svalid_q   <= 1'b1;
              captured_q <= 1'b1;
            end
            if (cnt_q == SLOT_LAST) begin
              cnt_q      <= '0;
              ch_q       <= nxt_ch;
              led_q      <= onehot(nxt_ch);
              dc_q       <= dc_tab_q[nxt_ch];
              gain_q     <= gain_tab_q[nxt_ch];
              captured_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_afe_calib_sequencer.sv
// Self-checking bench: step-level calibration model plus slot-level run-mode model,
// every output compared every cycle against the model's expectation.
module tb_afe_calib_sequencer;

  localparam int NUM_CH = 3;
  localparam int ADC_W = 8;
  localparam int DAC_W = 7;
  localparam int GAIN_W = 4;
  localparam int SETTLE = 16;
  localparam int SLOT = 64;
  localparam int TARGET = 127;
  localparam int CLIP_HI = 250;
  localparam int CLIP_LO = 5;
  localparam int GMAX = (1 << GAIN_W) - 1;
`ifdef CAL_AVG4_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic CLK = 1'b0;
  logic rst, start, adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic [NUM_CH-1:0] led_en, cal_err;
  logic [DAC_W-1:0] dc_comp;
  logic [GAIN_W-1:0] pga_gain;
  logic busy, cal_done, sample_valid;
  logic [ADC_W-1:0] sample_data;
  logic [1:0] sample_ch;

  always #5 CLK = ~CLK;

  afe_calib_sequencer #(
    .NUM_CH(NUM_CH), .ADC_W(ADC_W), .DAC_W(DAC_W), .GAIN_W(GAIN_W),
    .SETTLE_CYC(SETTLE), .SLOT_CYC(SLOT), .TARGET_MID(TARGET),
    .CLIP_HI(CLIP_HI), .CLIP_LO(CLIP_LO)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .adc_data(adc_data), .adc_valid(adc_valid),
    .led_en(led_en), .dc_comp(dc_comp), .pga_gain(pga_gain), .busy(busy),
    .cal_done(cal_done), .cal_err(cal_err), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_valid(sample_valid)
  );

  int total = 0;
  int bad = 0;

  // Expected outputs for the current cycle.
  logic [NUM_CH-1:0] e_led, e_err;
  logic [DAC_W-1:0] e_dc;
  logic [GAIN_W-1:0] e_gain;
  logic e_busy, e_done, e_sv;
  logic [ADC_W-1:0] e_sd;
  logic [1:0] e_sch;

  int dc_tab[NUM_CH];
  int g_tab[NUM_CH];
  // Simple AFE: reading falls with DC compensation and rises with gain, clamped to the ADC range.
  int base[NUM_CH] = '{190, 400, 150};
  int slope[NUM_CH] = '{16, 30, 40};

  function automatic int afe(int ch, int dc, int g);
    int v;
    v = base[ch] - dc + slope[ch] * g;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    chk("led_en", 32'(led_en), 32'(e_led));
    chk("dc_comp", 32'(dc_comp), 32'(e_dc));
    chk("pga_gain", 32'(pga_gain), 32'(e_gain));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cal_done", 32'(cal_done), 32'(e_done));
    chk("cal_err", 32'(cal_err), 32'(e_err));
    chk("sample_valid", 32'(sample_valid), 32'(e_sv));
    chk("sample_data", 32'(sample_data), 32'(e_sd));
    chk("sample_ch", 32'(sample_ch), 32'(e_sch));
  endtask

  // One calibration step; returns with the deciding cycle's inputs driven but not yet clocked.
  task automatic cal_step(input int ch, input int dc, input int g, input int pulse_at,
                          output int sample);
    int n, sum, v;
    for (int i = 0; i < SETTLE; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data = ADC_W'($urandom);
      start = (i == pulse_at);
      tick();
    end
    start = 1'b0;
    n = 0;
    sum = 0;
    for (int c = 0; c < 200; c++) begin
      v = (c % 8 == 7) ? 1 : int'($urandom_range(0, 3) != 0);
      adc_valid = 1'(v);
      adc_data = v ? ADC_W'(afe(ch, dc, g)) : ADC_W'($urandom);
      if (v != 0) begin
        sum += afe(ch, dc, g);
        n++;
        if (n == NS) break;
      end
      tick();
    end
    sample = sum / NS;
  endtask

  task automatic cal_dc(input int ch, input int pulse);
    int res, trial, s;
    res = 0;
    for (int k = DAC_W - 1; k >= 0; k--) begin
      trial = res | (1 << k);
      cal_step(ch, trial, 0, (k == DAC_W - 3) ? pulse : -1, s);
      if (s >= TARGET) res = trial;
      e_dc = (k > 0) ? DAC_W'(res | (1 << (k - 1))) : DAC_W'(res);
      tick();
    end
    dc_tab[ch] = res;
  endtask

  task automatic cal_gain(input int ch);
    int s;
    for (int g = 0; g <= GMAX; g++) begin
      cal_step(ch, dc_tab[ch], g, -1, s);
      if (s > CLIP_HI || s < CLIP_LO) begin
        g_tab[ch] = (g > 0) ? g - 1 : 0;
        if (g == 0) e_err[ch] = 1'b1;
        break;
      end
      if (g == GMAX) begin
        g_tab[ch] = GMAX;
        break;
      end
      e_gain = GAIN_W'(g + 1);
      tick();
    end
    e_busy = 1'b0;
    tick();
    adc_valid = 1'($urandom_range(0, 1));
    adc_data = ADC_W'($urandom);
    if (ch < NUM_CH - 1) begin
      e_led = NUM_CH'(1 << (ch + 1));
      e_dc = DAC_W'(1 << (DAC_W - 1));
      e_gain = '0;
      e_busy = 1'b1;
    end else begin
      e_led = NUM_CH'(1);
      e_dc = DAC_W'(dc_tab[0]);
      e_gain = GAIN_W'(g_tab[0]);
      e_done = 1'b1;
    end
    tick();
  endtask

  task automatic run_slot(input int ch, input bit allow, input int restart_at);
    bit captured;
    int nxt;
    logic v;
    logic [ADC_W-1:0] d;
    captured = 1'b0;
    for (int c = 0; c < SLOT; c++) begin
      v = allow ? ($urandom_range(0, 3) == 0) : 1'b0;
      d = ADC_W'($urandom);
      if (c == restart_at) begin
        start = 1'b1;
        adc_valid = 1'b0;
        adc_data = d;
        e_sv = 1'b0;
        e_led = NUM_CH'(1);
        e_dc = DAC_W'(1 << (DAC_W - 1));
        e_gain = '0;
        e_busy = 1'b1;
        e_done = 1'b0;
        e_err = '0;
        tick();
        start = 1'b0;
        return;
      end
      adc_valid = v;
      adc_data = d;
      e_sv = 1'b0;
      if (c >= SETTLE && !captured && v) begin
        captured = 1'b1;
        e_sv = 1'b1;
        e_sd = d;
        e_sch = 2'(ch);
      end
      if (c == SLOT - 1) begin
        nxt = (ch + 1) % NUM_CH;
        e_led = NUM_CH'(1 << nxt);
        e_dc = DAC_W'(dc_tab[nxt]);
        e_gain = GAIN_W'(g_tab[nxt]);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    e_led = '0; e_err = '0; e_dc = '0; e_gain = '0;
    e_busy = 1'b0; e_done = 1'b0; e_sv = 1'b0; e_sd = '0; e_sch = '0;
    #1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    start = 1'b1;
    e_led = NUM_CH'(1);
    e_dc = DAC_W'(1 << (DAC_W - 1));
    e_busy = 1'b1;
    tick();
    start = 1'b0;

    for (int ch = 0; ch < NUM_CH; ch++) begin
      cal_dc(ch, (ch == 0) ? 5 : -1);
      cal_gain(ch);
    end

    for (int s = 0; s < 7; s++) run_slot(s % NUM_CH, (s != 4), -1);
    run_slot(7 % NUM_CH, 1'b1, 30);

    cal_dc(0, -1);
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      adc_data = ADC_W'($urandom);
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    e_led = '0; e_err = '0; e_dc = '0; e_gain = '0;
    e_busy = 1'b0; e_done = 1'b0; e_sv = 1'b0; e_sd = '0; e_sch = '0;
    tick();
    rst = 1'b0;
    start = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afe_calib_sequencer.md
Name: afe_calib_sequencer

Overview:
Parametrised next-generation LED/AFE calibration controller for the PPG front end. Serves NUM_CH LED channels rather than a fixed red/IR pair. For each channel in turn it runs a successive-approximation search of the DC-compensation DAC to centre the ADC reading, then a monotonic PGA gain search up to the clipping limit, and stores both results. It then time-multiplexes the channels with the stored settings and emits one tagged ADC sample per slot to the downstream filters.

Parameters:
NUM_CH, 2, number of LED channels (2..8)
ADC_W, 8, ADC sample width
DAC_W, 7, DC-compensation DAC width
GAIN_W, 4, PGA gain code width
SETTLE_CYC, 16, cycles waited after any DAC/gain/LED change before sampling (>=1)
SLOT_CYC, 64, run-mode slot length in cycles (> SETTLE_CYC)
TARGET_MID, 127, DC search target code
CLIP_HI, 250, upper clip threshold
CLIP_LO, 5, lower clip threshold

Ports:
CLK  in  1  clock
rst  in  1  synchronous reset, active high
start  in  1  single-cycle pulse; begin or restart calibration
adc_data  in  ADC_W  ADC sample
adc_valid  in  1  adc_data valid this cycle
led_en  out  NUM_CH  one-hot LED drive, all zero when idle
dc_comp  out  DAC_W  DC-compensation DAC code
pga_gain  out  GAIN_W  PGA gain code
busy  out  1  high in DC_SEARCH/GAIN_SEARCH
cal_done  out  1  high in RUN
cal_err  out  NUM_CH  per-channel flag: clipping at gain 0
sample_data  out  ADC_W  captured run-mode sample
sample_ch  out  clog2(NUM_CH) (min 1)  channel of sample_data
sample_valid  out  1  one-cycle strobe

Behaviour:
- Reset: state IDLE. All outputs 0. Stored per-channel dc/gain tables cleared to 0. Reset mid-operation aborts immediately.
- States: IDLE, DC_SEARCH, GAIN_SEARCH, NEXT_CH, RUN.
- IDLE: start=1 -> DC_SEARCH with ch=0, led_en=1<<0, pga_gain=0, dc_comp=MSB only, settle counter loaded.
- Settle rule: each "step" waits SETTLE_CYC cycles after the output change. It then takes the first adc_valid sample; that sample's cycle ends the step. No adc_valid means it waits indefinitely.
- DC_SEARCH: SAR, MSB to LSB, exactly DAC_W steps. At step k, trial bit k is set. If sample < TARGET_MID, bit k is cleared, else kept. The next lower bit is then set. After the LSB decision, the dc_comp result is stored -> GAIN_SEARCH with pga_gain=0.
- GAIN_SEARCH: dc_comp held.
  - Clip = sample > CLIP_HI or sample < CLIP_LO.
  - Clip at gain g>0: store g-1.
  - Clip at gain 0: store 0, set cal_err[ch].
  - No clip at g = all-ones: store max.
  - Otherwise gain+1, new step.
  - On store -> NEXT_CH.
- NEXT_CH (1 cycle): if ch==NUM_CH-1 -> RUN with ch=0. Else ch+1, led_en one-hot, dc_comp=MSB, gain=0 -> DC_SEARCH.
- RUN: slot counter 0..SLOT_CYC-1. At counter 0, led_en/dc_comp/pga_gain load channel ch's stored values. At counter >= SETTLE_CYC, the first adc_valid of the slot is captured: sample_data<=adc_data, sample_ch<=ch, sample_valid=1 for one cycle the next cycle. At most one sample per slot; a slot with none emits nothing. At counter SLOT_CYC-1, ch wraps modulo NUM_CH.
- start while busy: ignored. start in RUN: restart calibration from channel 0, cal_err cleared, cal_done drops next cycle.
- start and rst same cycle: rst wins.
- All comparisons unsigned; counters sized clog2(SLOT_CYC+1).

Optional Feature:
CAL_AVG4_EN. When defined, every calibration step averages the first 4 adc_valid samples after settling: a (ADC_W+2)-bit sum, shifted right 2 and truncated, and the decision uses the average. Run-mode capture is unchanged. When undefined, a single sample decides, as above. Step length grows by the extra valid samples only.

Test Plan:
- DC SAR: NUM_CH=1, bench model adc=190-dc_comp (gain 0), adc_valid every cycle -> dc search steps 64,32(+ kept bits)..., final stored dc_comp=63, exactly 7 steps each SETTLE_CYC+1 cycles.
- Gain search: model adc=127+16*gain -> gains 0..7 pass, gain 8 gives 255 (clip), stored pga_gain=7, cal_err=0.
- Clip at zero: model adc constant 255 -> stored gain 0, cal_err[ch]=1, sequence still reaches RUN.
- Multi-channel RUN: NUM_CH=3, distinct models per channel -> led_en 001,010,100 rotating every 64 cycles, each slot applies its channel's stored dc/gain, sample_ch 0,1,2,0 with one sample_valid per slot.
- Handshake gaps: adc_valid low throughout a RUN slot -> no sample_valid for that slot, next slot normal. start pulsed mid-DC_SEARCH -> ignored.
- Reset mid-GAIN_SEARCH -> next cycle all outputs 0, state IDLE. Start in RUN -> busy=1, cal_done=0, calibration restarts at ch 0.
